// File: rtl/cache_if.sv
// ----------------------------------------------------------------------------
// cache_if
// Access port of an N-way cache bank.
//   master : memory-controller side; drives the access request
//            (enable, tag_in, index, offset, data_in, comp, write, valid_in)
//            and observes the result.
//   slave  : cache bank side; returns tag_out, data_out, hit, dirty, valid,
//            way_sel and err combinationally from the request.
// WAY_W must equal $clog2(WAYS) of the attached bank.
// ----------------------------------------------------------------------------
interface cache_if #(
    parameter int TAG_W    = 5,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    parameter int DATA_W   = 16,
    parameter int WAY_W    = 2
);
    logic                enable;
    logic [TAG_W-1:0]    tag_in;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   data_in;
    logic                comp;
    logic                write;
    logic                valid_in;
    logic [TAG_W-1:0]    tag_out;
    logic [DATA_W-1:0]   data_out;
    logic                hit;
    logic                dirty;
    logic                valid;
    logic [WAY_W-1:0]    way_sel;
    logic                err;

    modport master (
        output enable, tag_in, index, offset, data_in, comp, write, valid_in,
        input  tag_out, data_out, hit, dirty, valid, way_sel, err
    );

    modport slave (
        input  enable, tag_in, index, offset, data_in, comp, write, valid_in,
        output tag_out, data_out, hit, dirty, valid, way_sel, err
    );
endinterface

// File: rtl/cache_nway.sv
// ----------------------------------------------------------------------------
// cache_nway
// N-way set-associative cache bank with tree pseudo-LRU replacement and a
// victim lock that keeps the chosen way stable across a fill/evict sequence.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        cache_if.slave access port (request in, result out)
//   clr_stats  (CACHE_NWAY_STATS_EN only) synchronous clear of the counters
//   hit_cnt    (CACHE_NWAY_STATS_EN only) saturating compare-hit count
//   miss_cnt   (CACHE_NWAY_STATS_EN only) saturating compare-miss count
//
// Optional feature macro: CACHE_NWAY_STATS_EN (hit/miss statistics counters).
//
// Outputs are combinational from current state and request; enable=0 drives
// all outputs to zero. Tag and data arrays carry no reset; valid, dirty, PLRU
// and lock state do.
// ----------------------------------------------------------------------------
module cache_nway #(
    parameter int WAYS     = 4,
    parameter int TAG_W    = 5,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    parameter int DATA_W   = 16,
    parameter int MEM_TYPE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef CACHE_NWAY_STATS_EN
    input  logic        clr_stats,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    cache_if.slave      bus
);

    localparam int SETS   = 1 << INDEX_W;
    localparam int WORDS  = 1 << (OFFSET_W - 1);
    localparam int WORD_W = OFFSET_W - 1;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    // Elaboration-time parameter sanity checks
    if ((WAYS < 2) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
        $error("cache_nway: WAYS must be a power of 2 and >= 2");
    end
    if ((MEM_TYPE != 0) && (MEM_TYPE != 1)) begin : g_bad_mem_type
        $error("cache_nway: MEM_TYPE must be 0 (instruction) or 1 (data)");
    end

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // Tree PLRU victim: walk from the root, each bit picks the half to evict
    // from (0 = lower half). Bits along the path form the way number MSB first.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic             b;
        node = '0;
        way  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b                = bits[node];
            way[WAY_W-1-l]   = b;
            node             = (node << 1'b1) + WAY_W'(1'b1) + WAY_W'(b);
        end
        return way;
    endfunction

    // Tree PLRU touch: every node on the path to way w is set to point away
    // from w, so w becomes the most recently used way in this set.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] nb;
        logic [WAY_W-1:0]  node;
        logic              d;
        nb   = bits;
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            d        = way[WAY_W-1-l];
            nb[node] = ~d;
            node     = (node << 1'b1) + WAY_W'(1'b1) + WAY_W'(d);
        end
        return nb;
    endfunction

    // Storage
    logic [TAG_W-1:0]  tag_mem_r  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem_r [SETS][WAYS][WORDS];
    logic [SETS-1:0][WAYS-1:0]   valid_r;
    logic [SETS-1:0][WAYS-1:0]   dirty_r;
    logic [SETS-1:0][PLRU_W-1:0] plru_r;

    lock_state_e      lock_state_r;
    lock_state_e      lock_state_s;
    logic [WAY_W-1:0] vict_q_r;
    logic [WAY_W-1:0] vict_q_s;

    // Lookup
    logic [WAYS-1:0]   match_s;
    logic [WAYS-1:0]   set_valid_s;
    logic [PLRU_W-1:0] set_plru_s;
    logic              any_match_s;
    logic              multi_match_s;
    logic              all_valid_s;
    logic [WAY_W-1:0]  match_way_s;
    logic [WAY_W-1:0]  free_way_s;
    logic [WAY_W-1:0]  plru_way_s;
    logic [WAY_W-1:0]  sel_way_s;
    logic [WORD_W-1:0] word_s;
    logic              hit_s;
    logic              err_s;
    logic              cmp_wr_s;
    logic              dir_wr_s;
    logic              touch_s;

    // Tag compare across all ways of the addressed set, lowest-index priority
    always_comb begin
        set_valid_s = valid_r[bus.index];
        set_plru_s  = plru_r[bus.index];
        word_s      = bus.offset[OFFSET_W-1:1];
        match_way_s = '0;
        free_way_s  = '0;
        for (int w = 0; w < WAYS; w++) begin
            match_s[w] = set_valid_s[w] & (tag_mem_r[bus.index][w] == bus.tag_in);
        end
        // Descending scan so the lowest qualifying way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match_s[w]) begin
                match_way_s = w[WAY_W-1:0];
            end else begin
                match_way_s = match_way_s;
            end
            if (!set_valid_s[w]) begin
                free_way_s = w[WAY_W-1:0];
            end else begin
                free_way_s = free_way_s;
            end
        end
        any_match_s   = |match_s;
        multi_match_s = |(match_s & (match_s - {{(WAYS-1){1'b0}}, 1'b1}));
        all_valid_s   = &set_valid_s;
        plru_way_s    = plru_victim(set_plru_s);
    end

    // Way selection, hit/err qualification and write strobes
    always_comb begin
        if (bus.comp || (lock_state_r != LOCK_LOCKED)) begin
            if (any_match_s) begin
                sel_way_s = match_way_s;
            end else if (!all_valid_s) begin
                sel_way_s = free_way_s;
            end else begin
                sel_way_s = plru_way_s;
            end
        end else begin
            // Direct access during a fill/evict keeps the locked victim
            sel_way_s = vict_q_r;
        end
        hit_s    = bus.comp & any_match_s;
        err_s    = bus.enable & (bus.offset[0] | multi_match_s);
        cmp_wr_s = bus.enable & bus.comp & bus.write & hit_s & ~err_s;
        dir_wr_s = bus.enable & ~bus.comp & bus.write & ~err_s;
        touch_s  = (bus.enable & bus.comp & hit_s & ~err_s) | dir_wr_s;
    end

    // Result port; everything reads as zero when no access is presented
    always_comb begin
        bus.tag_out  = '0;
        bus.data_out = '0;
        bus.hit      = 1'b0;
        bus.dirty    = 1'b0;
        bus.valid    = 1'b0;
        bus.way_sel  = '0;
        bus.err      = 1'b0;
        if (bus.enable) begin
            bus.tag_out  = tag_mem_r[bus.index][sel_way_s];
            bus.data_out = data_mem_r[bus.index][sel_way_s][word_s];
            bus.hit      = hit_s;
            bus.dirty    = dirty_r[bus.index][sel_way_s];
            bus.valid    = valid_r[bus.index][sel_way_s];
            bus.way_sel  = sel_way_s;
            bus.err      = err_s;
        end else begin
            bus.tag_out  = '0;
        end
    end

    // Tag and data arrays (no reset)
    always_ff @(posedge clk) begin
        if (cmp_wr_s || dir_wr_s) begin
            data_mem_r[bus.index][sel_way_s][word_s] <= bus.data_in;
        end
        if (dir_wr_s) begin
            tag_mem_r[bus.index][sel_way_s] <= bus.tag_in;
        end
    end

    // Valid, dirty and PLRU state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            dirty_r <= '0;
            plru_r  <= '0;
        end else begin
            if (cmp_wr_s) begin
                dirty_r[bus.index][sel_way_s] <= 1'b1;
            end else if (dir_wr_s) begin
                valid_r[bus.index][sel_way_s] <= bus.valid_in;
                dirty_r[bus.index][sel_way_s] <= 1'b0;
            end
            if (touch_s) begin
                plru_r[bus.index] <= plru_touch(set_plru_s, sel_way_s);
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_r <= LOCK_IDLE;
            vict_q_r     <= '0;
        end else begin
            lock_state_r <= lock_state_s;
            vict_q_r     <= vict_q_s;
        end
    end

    // Lock FSM next state: every compare access releases the lock and a
    // compare miss (re)captures the selected way on the same edge
    always_comb begin
        lock_state_s = lock_state_r;
        vict_q_s     = vict_q_r;
        case (lock_state_r)
            LOCK_IDLE, LOCK_LOCKED: begin
                if (bus.enable && bus.comp) begin
                    if (!hit_s) begin
                        lock_state_s = LOCK_LOCKED;
                        vict_q_s     = sel_way_s;
                    end else begin
                        lock_state_s = LOCK_IDLE;
                    end
                end else begin
                    lock_state_s = lock_state_r;
                end
            end
            default: begin
                lock_state_s = LOCK_IDLE;
            end
        endcase
    end

`ifdef CACHE_NWAY_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Saturating hit/miss statistics for error-free compare accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else if (clr_stats) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else if (bus.enable && bus.comp && !err_s) begin
            if (hit_s) begin
                if (hit_cnt_r != 16'hFFFF) begin
                    hit_cnt_r <= hit_cnt_r + 16'd1;
                end
            end else begin
                if (miss_cnt_r != 16'hFFFF) begin
                    miss_cnt_r <= miss_cnt_r + 16'd1;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_cache_nway.sv
// ----------------------------------------------------------------------------
// tb_cache_nway
// Directed self-checking bench for cache_nway (WAYS=4, TAG_W=5, INDEX_W=8,
// OFFSET_W=3, DATA_W=16). Inputs change 1 ns after the rising edge and the
// combinational outputs are sampled 3 ns later, well before the next edge.
// ----------------------------------------------------------------------------
module tb_cache_nway;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cache_if #(.TAG_W(5), .INDEX_W(8), .OFFSET_W(3), .DATA_W(16), .WAY_W(2)) bus ();

`ifdef CACHE_NWAY_STATS_EN
    logic        clr_stats;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cache_nway #(
        .WAYS(4), .TAG_W(5), .INDEX_W(8), .OFFSET_W(3), .DATA_W(16), .MEM_TYPE(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CACHE_NWAY_STATS_EN
        .clr_stats(clr_stats),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic cp, input logic wr,
                         input logic [4:0] tg, input logic [7:0] idx,
                         input logic [2:0] off, input logic [15:0] d,
                         input logic vi);
        bus.enable   = en;
        bus.comp     = cp;
        bus.write    = wr;
        bus.tag_in   = tg;
        bus.index    = idx;
        bus.offset   = off;
        bus.data_in  = d;
        bus.valid_in = vi;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.tag_out, bus.data_out, bus.hit, bus.dirty, bus.valid, bus.way_sel, bus.err} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.tag_out, bus.data_out, bus.hit, bus.dirty, bus.valid, bus.way_sel, bus.err});
        end
        tick();
        rst_n = 1'b1;
        tick();
        // Compare read on an empty set: miss into way 0, locks way 0
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.valid, bus.way_sel, bus.err} !== {1'b0, 1'b0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_first_miss got=%b exp=00000", {bus.hit, bus.valid, bus.way_sel, bus.err});
        end
        tick();
    endtask

    task automatic test_direct_fill();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'h03, 8'h10, 3'(2 * k), 16'hA000 + 16'(k), 1'b1);
            checks++;
            if (bus.way_sel !== 2'd0) begin
                failures++;
                $display("FAIL fill_way k=%0d got=%0d exp=0", k, bus.way_sel);
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd4, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.dirty, bus.valid, bus.way_sel, bus.data_out, bus.tag_out} !== {1'b1, 1'b0, 1'b1, 2'd0, 16'hA002, 5'h03}) begin
            failures++;
            $display("FAIL fill_read got=%h exp=%h", {bus.hit, bus.dirty, bus.valid, bus.way_sel, bus.data_out, bus.tag_out},
                     {1'b1, 1'b0, 1'b1, 2'd0, 16'hA002, 5'h03});
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd6, 16'h0000, 1'b0);
        checks++;
        if (bus.data_out !== 16'hA003) begin
            failures++;
            $display("FAIL fill_read_off6 got=%h exp=a003", bus.data_out);
        end
        tick();
    endtask

    task automatic test_compare_write();
        drive(1'b1, 1'b1, 1'b1, 5'h03, 8'h10, 3'd4, 16'h1234, 1'b0);
        checks++;
        if (bus.hit !== 1'b1) begin
            failures++;
            $display("FAIL cwr_hit got=%b exp=1", bus.hit);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd4, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.dirty, bus.data_out} !== {1'b1, 1'b1, 16'h1234}) begin
            failures++;
            $display("FAIL cwr_readback got=%h exp=%h", {bus.hit, bus.dirty, bus.data_out}, {1'b1, 1'b1, 16'h1234});
        end
        tick();
        // Compare write miss: lowest invalid way offered, nothing stored
        drive(1'b1, 1'b1, 1'b1, 5'h07, 8'h10, 3'd4, 16'hFFFF, 1'b0);
        checks++;
        if ({bus.hit, bus.valid, bus.way_sel} !== {1'b0, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL cwr_miss got=%b exp=0001", {bus.hit, bus.valid, bus.way_sel});
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd4, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.data_out} !== {1'b1, 16'h1234}) begin
            failures++;
            $display("FAIL cwr_miss_nochange got=%h exp=%h", {bus.hit, bus.data_out}, {1'b1, 16'h1234});
        end
        tick();
    endtask

    task automatic test_plru_lock();
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, 1'b1, 1'b0, 5'(t), 8'h20, 3'd0, 16'h0000, 1'b0);
            checks++;
            if ({bus.hit, bus.way_sel} !== {1'b0, 2'(t - 1)}) begin
                failures++;
                $display("FAIL plru_fill_miss t=%0d got=%b exp=%b", t, {bus.hit, bus.way_sel}, {1'b0, 2'(t - 1)});
            end
            tick();
            drive(1'b1, 1'b0, 1'b1, 5'(t), 8'h20, 3'd0, 16'h0100 + 16'(t), 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 5'h01, 8'h20, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.way_sel, bus.data_out} !== {1'b1, 2'd0, 16'h0101}) begin
            failures++;
            $display("FAIL plru_touch_hit got=%h exp=%h", {bus.hit, bus.way_sel, bus.data_out}, {1'b1, 2'd0, 16'h0101});
        end
        tick();
        // Tree bits now root=1,left=1,right=0 -> victim way 2
        drive(1'b1, 1'b1, 1'b0, 5'h05, 8'h20, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.valid, bus.way_sel} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL plru_victim got=%b exp=0110", {bus.hit, bus.valid, bus.way_sel});
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 5'h05, 8'h20, 3'(2 * k), 16'hB000 + 16'(k), 1'b1);
            checks++;
            if (bus.way_sel !== 2'd2) begin
                failures++;
                $display("FAIL lock_way k=%0d got=%0d exp=2", k, bus.way_sel);
            end
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 5'h05, 8'h20, 3'd6, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.dirty, bus.way_sel, bus.data_out} !== {1'b1, 1'b0, 2'd2, 16'hB003}) begin
            failures++;
            $display("FAIL lock_refill_read got=%h exp=%h", {bus.hit, bus.dirty, bus.way_sel, bus.data_out}, {1'b1, 1'b0, 2'd2, 16'hB003});
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h04, 8'h20, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.way_sel, bus.data_out} !== {1'b1, 2'd3, 16'h0104}) begin
            failures++;
            $display("FAIL plru_way3_hit got=%h exp=%h", {bus.hit, bus.way_sel, bus.data_out}, {1'b1, 2'd3, 16'h0104});
        end
        tick();
        // Tag 3 was evicted; tree now root=0,left=1 -> victim way 1
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h20, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.hit, bus.valid, bus.way_sel} !== {1'b0, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL plru_second_victim got=%b exp=0101", {bus.hit, bus.valid, bus.way_sel});
        end
        tick();
    endtask

    task automatic test_err();
        drive(1'b1, 1'b1, 1'b1, 5'h03, 8'h10, 3'b001, 16'h5555, 1'b0);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL err_odd_offset got=%b exp=1", bus.err);
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.err, bus.hit, bus.dirty, bus.data_out} !== {1'b0, 1'b1, 1'b1, 16'hA000}) begin
            failures++;
            $display("FAIL err_no_write got=%h exp=%h", {bus.err, bus.hit, bus.dirty, bus.data_out}, {1'b0, 1'b1, 1'b1, 16'hA000});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 5'h03, 8'h10, 3'b001, 16'h5555, 1'b1);
        checks++;
        if ({bus.tag_out, bus.data_out, bus.hit, bus.dirty, bus.valid, bus.way_sel, bus.err} !== 27'd0) begin
            failures++;
            $display("FAIL disable_zero got=%h exp=0", {bus.tag_out, bus.data_out, bus.hit, bus.dirty, bus.valid, bus.way_sel, bus.err});
        end
        tick();
        // Build a duplicate tag in ways 0 and 1 of set 0x30
        drive(1'b1, 1'b1, 1'b0, 5'h09, 8'h30, 3'd0, 16'h0000, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'h09, 8'h30, 3'd0, 16'hC000, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h0A, 8'h30, 3'd0, 16'h0000, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'h09, 8'h30, 3'd0, 16'hC001, 1'b1);
        checks++;
        if (bus.way_sel !== 2'd1) begin
            failures++;
            $display("FAIL dup_lock_way got=%0d exp=1", bus.way_sel);
        end
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'h09, 8'h30, 3'd0, 16'hDEAD, 1'b0);
        checks++;
        if ({bus.err, bus.hit, bus.way_sel, bus.data_out} !== {1'b1, 1'b1, 2'd0, 16'hC000}) begin
            failures++;
            $display("FAIL multi_hit got=%h exp=%h", {bus.err, bus.hit, bus.way_sel, bus.data_out}, {1'b1, 1'b1, 2'd0, 16'hC000});
        end
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'h09, 8'h30, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({bus.dirty, bus.data_out} !== {1'b0, 16'hC000}) begin
            failures++;
            $display("FAIL multi_hit_no_write got=%h exp=%h", {bus.dirty, bus.data_out}, {1'b0, 16'hC000});
        end
        tick();
    endtask

`ifdef CACHE_NWAY_STATS_EN
    task automatic test_stats();
        clr_stats = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 3'd0, 16'h0000, 1'b0);
        tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd0, 16'h0000, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'h0C, 8'h10, 3'd0, 16'h0000, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 3'd0, 16'h0000, 1'b0);
        checks++;
        if ({hit_cnt, miss_cnt} !== {16'd3, 16'd2}) begin
            failures++;
            $display("FAIL stats_count got=%h exp=00030002", {hit_cnt, miss_cnt});
        end
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        #3;
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'd0) begin
            failures++;
            $display("FAIL stats_clear got=%h exp=0", {hit_cnt, miss_cnt});
        end
        force dut.hit_cnt_r = 16'hFFFE;
        #1;
        release dut.hit_cnt_r;
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'h03, 8'h10, 3'd0, 16'h0000, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 3'd0, 16'h0000, 1'b0);
        checks++;
        if (hit_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_saturate got=%h exp=ffff", hit_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
`ifdef CACHE_NWAY_STATS_EN
        clr_stats = 1'b0;
`endif
        test_reset();
        test_direct_fill();
        test_compare_write();
        test_plru_lock();
        test_err();
`ifdef CACHE_NWAY_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
